// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin scheduler sharing one UART transmitter among
//            NUM_REQ byte sources. Each accepted byte produces one tx_start
//            pulse. The next byte is launched only after the transmitter's
//            tx_busy has risen and fallen again. Optional message locking
//            keeps a multi-byte message contiguous, with a burst limit that
//            forces rotation.
// Ports    : clk, reset       - clock, asynchronous active-high reset
//            req_valid/data/last/ready - per-requester byte handshake
//                               (req_ready is combinational and one-hot)
//            tx_start, tx_data - registered launch pulse and byte to the UART
//            tx_busy          - transmitter busy flag
//            grant_id, locked - owner of the last accepted byte, lock flag
//            err_timeout      - one-cycle pulse when tx_busy never rose
//            sched_idle       - IDLE state with no lock held
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       err_timeout,
    output logic                       sched_idle
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    // The counter only needs to reach ACK_TIMEOUT-1: the timeout fires on
    // the cycle the incremented value would equal ACK_TIMEOUT.
    localparam int c_CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_ID_W-1:0]   r_grant;
    logic                r_locked;
    logic [7:0]          r_burst;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_err;

    logic [c_ID_W-1:0]   w_sel;
    logic [c_ID_W-1:0]   w_idx;
    logic                w_found;
    logic                w_go;
    logic [7:0]          w_byte;
    logic [7:0]          w_burst_inc;
    logic                w_release;

    // Arbitration: a held lock restricts eligibility to its owner; otherwise
    // search ptr+1, ptr+2, ... The loop runs from the farthest offset down so
    // the nearest valid requester is the one that sticks.
    always_comb begin
        w_sel   = r_grant;
        w_idx   = '0;
        w_found = 1'b0;
        if (r_locked) begin
            w_found = req_valid[r_grant];
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                w_idx = c_ID_W'((int'(r_ptr) + k) % NUM_REQ);
                if (req_valid[w_idx]) begin
                    w_sel   = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == c_ID_W'(i)) begin
                w_byte = req_data[8*i +: 8];
            end
        end
    end

    assign w_go        = (r_state == S_IDLE) && !tx_busy && w_found;
    assign w_burst_inc = (r_burst >= 8'(MAX_BURST)) ? r_burst : r_burst + 8'd1;
    assign w_release   = req_last[w_sel] || (w_burst_inc == 8'(MAX_BURST));

    // Gated by reset so the strobe drops in the very cycle reset is applied.
    assign req_ready   = (w_go && !reset) ?
                         ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= c_ID_W'(NUM_REQ - 1);
            r_grant    <= '0;
            r_locked   <= 1'b0;
            r_burst    <= 8'd0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_tx_data  <= w_byte;
                        r_grant    <= w_sel;
                        r_ptr      <= w_sel;
                        r_tx_start <= 1'b1;
                        r_state    <= S_LAUNCH;
                        if (w_release) begin
                            r_locked <= 1'b0;
                            r_burst  <= 8'd0;
                        end else begin
                            r_locked <= 1'b1;
                            r_burst  <= w_burst_inc;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_cnt == c_CNT_W'(ACK_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: drop any lock so a
                        // stuck message cannot starve the other requesters.
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_burst  <= 8'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant;
    assign locked      = r_locked;
    assign err_timeout = r_err;
    assign sched_idle  = (r_state == S_IDLE) && !r_locked;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched. It covers reset values,
//            a combinational ready table, directed single-byte, timeout and
//            mid-operation reset sequences, and a randomized message stream
//            checked against a transaction-level scheduling model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int AT = 15;
    localparam int BL = 3;   // cycles the modelled transmitter stays busy

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;
    logic           locked;
    logic           err_timeout;
    logic           sched_idle;

    uart_tx_sched #(.NUM_REQ(N), .MAX_BURST(MB), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked),
        .err_timeout(err_timeout), .sched_idle(sched_idle)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_left = 0;
    bit mute = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; the transmitter raises tx_busy the cycle after it
    // sees tx_start and keeps it high for BL cycles (unless muted).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (tx_start && !mute) busy_left = BL;
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         busy;
        logic [N-1:0] ready;
    } vec_t;
    vec_t vt[9];

    // Randomized-phase state: per-requester byte queues {last, data} and the
    // scheduling model.
    logic [8:0] q [N][$];
    logic [8:0] ent;
    logic [7:0] exp_byte;
    int  m_ptr, m_owner, m_cnt, m_gid, next_opp, exp_start, g, idx;
    int  len, pending, n_total, n_acc, a, ts;
    bit  m_lock, more, done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset values ----------------
        req_valid = '1;
        step(); step();
        chk("rst_ready", req_ready, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_idle", sched_idle, 1);
        req_valid = '0;
        reset = 1'b0;

        // ---------------- ready table (ptr starts at N-1) ----------------
        vt[0] = '{4'b0000, 1'b0, 4'b0000};
        vt[1] = '{4'b0001, 1'b0, 4'b0001};
        vt[2] = '{4'b0101, 1'b0, 4'b0001};
        vt[3] = '{4'b0100, 1'b0, 4'b0100};
        vt[4] = '{4'b1100, 1'b0, 4'b0100};
        vt[5] = '{4'b1000, 1'b0, 4'b1000};
        vt[6] = '{4'b1111, 1'b1, 4'b0000};
        vt[7] = '{4'b1110, 1'b0, 4'b0010};
        vt[8] = '{4'b1111, 1'b0, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            req_valid = vt[i].valid;
            tx_busy   = vt[i].busy;
            #1;
            chk($sformatf("tbl_ready_%0d", i), req_ready, vt[i].ready);
        end
        req_valid = '0;
        tx_busy   = 1'b0;

        // ---------------- single byte 0xA5 from requester 0 ----------------
        step();
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        a = cyc;
        step();
        req_valid = '0;
        chk("t1_tx_start", tx_start, 1);
        chk("t1_tx_data", tx_data, 8'hA5);
        chk("t1_grant", grant_id, 0);
        chk("t1_locked", locked, 0);
        chk("t1_busy_state", sched_idle, 0);
        for (int n = 0; n < 30; n++) begin
            step();
            if (cyc == a + 2) chk("t1_pulse_len", tx_start, 0);
            if (sched_idle) break;
        end
        chk("t1_idle_cycle", cyc - a, 3 + BL);
        chk("t1_data_held", tx_data, 8'hA5);

        // ---------------- timeout: transmitter never acknowledges ----------------
        mute = 1'b1;
        req_valid = 4'b0110; req_data[15:8] = 8'h31; req_data[23:16] = 8'h42;
        req_last = 4'b0000;
        #1;
        chk("t5_ready", req_ready, 4'b0010);
        step();
        chk("t5_tx_start", tx_start, 1);
        chk("t5_locked", locked, 1);
        ts = cyc;
        for (int n = 0; n < 40; n++) begin
            step();
            if (err_timeout) break;
        end
        chk("t5_err_cycle", cyc - ts, AT + 1);
        chk("t5_err", err_timeout, 1);
        chk("t5_lock_clr", locked, 0);
        chk("t5_idle", sched_idle, 1);
        req_last = 4'b0100;
        mute = 1'b0;
        #1;
        chk("t5_next_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        chk("t5_err_pulse", err_timeout, 0);
        chk("t5_tx_data", tx_data, 8'h42);
        chk("t5_grant", grant_id, 2);
        for (int n = 0; n < 30; n++) begin
            step();
            if (sched_idle) break;
        end
        chk("t5_drain", sched_idle, 1);

        // ---------------- reset while in WAIT_LO ----------------
        req_valid = 4'b1000; req_data[31:24] = 8'h5A; req_last = 4'b1000;
        #1;
        chk("t6_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        step(); step();   // transmitter busy: WAIT_HI then WAIT_LO
        req_valid = 4'b0101;
        reset = 1'b1;
        #1;
        chk("t6_ready_rst", req_ready, 0);
        chk("t6_tx_start", tx_start, 0);
        chk("t6_tx_data", tx_data, 0);
        chk("t6_grant", grant_id, 0);
        chk("t6_idle", sched_idle, 1);
        busy_left = 0; tx_busy = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_tie", req_ready, 4'b0001);
        req_valid = '0;

        // ---------------- randomized messages vs model ----------------
        n_total = 0;
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < 3; m++) begin
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) begin
                    q[i].push_back({(b == len - 1), 8'($urandom)});
                    n_total++;
                end
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0; busy_left = 0; tx_busy = 1'b0;
        m_ptr = N - 1; m_lock = 1'b0; m_owner = 0; m_cnt = 0; m_gid = 0;
        next_opp = cyc; exp_start = -1; exp_byte = 8'h00; n_acc = 0;
        done = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            more = (cyc < next_opp) || m_lock;
            for (int i = 0; i < N; i++) if (q[i].size() != 0) more = 1'b1;
            if (!more) begin
                done = 1'b1;
                break;
            end
            chk("rnd_tx_start", tx_start, (cyc == exp_start));
            if (cyc == exp_start) chk("rnd_tx_data", tx_data, exp_byte);
            chk("rnd_locked", locked, m_lock);
            chk("rnd_grant", grant_id, m_gid);
            chk("rnd_idle", sched_idle, (cyc >= next_opp) && !m_lock);
            chk("rnd_err", err_timeout, 0);
            for (int i = 0; i < N; i++) begin
                if (q[i].size() != 0 && $urandom_range(0, 3) != 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = q[i][0][7:0];
                    req_last[i] = q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i] = 1'($urandom);
                end
            end
            #1;
            g = -1;
            if (cyc >= next_opp && !tx_busy) begin
                if (m_lock) begin
                    if (req_valid[m_owner]) g = m_owner;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (g < 0 && req_valid[idx]) g = idx;
                    end
                end
            end
            chk("rnd_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                ent = q[g].pop_front();
                n_acc++;
                exp_byte = ent[7:0];
                exp_start = cyc + 1;
                next_opp = cyc + 3 + BL;
                m_gid = g;
                m_ptr = g;
                m_cnt = m_cnt + 1;
                if (ent[8] || m_cnt >= MB) begin
                    m_lock = 1'b0;
                    m_cnt = 0;
                end else begin
                    m_lock = 1'b1;
                    m_owner = g;
                end
            end
            step();
        end
        pending = 0;
        for (int i = 0; i < N; i++) pending += q[i].size();
        chk("rnd_done", done, 1);
        chk("rnd_pending", pending, 0);
        chk("rnd_accepted", n_acc, n_total);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
